mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Iterative HI/LO multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI, MTLO.
//   Sits directly downstream of the register file: takes rs/rt read data (data1/data2)
//   and owns the HI/LO pair that MFHI/MFLO read.
//   Uses shift-add multiply and restoring divide, one bit per cycle, with a busy/done handshake.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are WIDTH bits each
//   CNT_W   5    iteration counter width, clog2(WIDTH)
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      request operation; sampled only when busy=0
//   op          in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data     in   WIDTH  multiplicand / dividend (register file data1)
//   rt_data     in   WIDTH  multiplier / divisor (register file data2)
//   hi_we       in   1      MTHI: HI <= wdata
//   lo_we       in   1      MTLO: LO <= wdata
//   wdata       in   WIDTH  MTHI/MTLO data (rs)
//   busy        out  1      operation in progress
//   done        out  1      one-cycle pulse; HI/LO valid
//   div_by_zero out  1      set with done when a DIV/DIVU had rt=0; cleared on next start
//   hi          out  WIDTH  HI register
//   lo          out  WIDTH  LO register
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; busy=0; done=0; div_by_zero=0; hi=0; lo=0; counter=0.
//   States: IDLE -> MUL | DIV -> IDLE.
//   IDLE: at an edge with start=1, latch op and the operand magnitudes
//     - signed ops: |rs|, |rt|; record the result sign and the dividend sign
//     - go to MUL (op[1]=0) or DIV (op[1]=1); busy=1 after that edge; counter=0.
//   MUL/DIV: one iteration per edge, WIDTH iterations in total.
//     - The edge that performs iteration WIDTH also:
//       applies the sign fix-up (two's-complement negate);
//       writes hi/lo;
//       sets done=1 and busy=0; returns to IDLE.
//     - Latency: start sampled at edge E -> hi/lo valid and done=1 after edge E+WIDTH.
//   done is high for exactly one cycle. hi/lo hold until the next completion or MTHI/MTLO.
//   MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product. Signed product is negated when operand signs differ.
//   DIV/DIVU results:
//     - lo = quotient, truncated toward zero; hi = remainder.
//     - Remainder sign follows the dividend; quotient is negated when operand signs differ.
//   Divide by zero: still takes WIDTH cycles. Result lo=all ones, hi=rs_data as latched. div_by_zero=1.
//   Signed overflow: -2^31 / -1 gives lo=0x80000000, hi=0.
//   start while busy=1: ignored. The operation in flight is not disturbed and no request is queued.
//   hi_we/lo_we while busy=1: ignored.
//   hi_we/lo_we while IDLE: write at the edge.
//     - If start is also high at that edge, the write happens and the operation starts.
//     - The completing operation later overwrites hi/lo.
//   Completion edge coinciding with hi_we/lo_we: hi_we/lo_we are ignored (busy=1); the result wins.
//   Reset mid-operation: aborts immediately. All outputs take their reset values and no done is issued.
//   Operands are captured at start; later changes on rs_data/rt_data have no effect.
// TESTING
//   1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 32 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
//   2. MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//      MULT 20*45 -> hi=0, lo=900.
//   3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIVU 45/10 -> lo=4, hi=5.
//      DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4. DIVU 100/0 -> done after 32 cycles; lo=0xFFFFFFFF, hi=0x64, div_by_zero=1.
//      div_by_zero clears on the next start.
//   5. start a new op and assert hi_we at cycle 10 of a MULT -> both ignored.
//      Only the original result appears; a single done pulse.
//   6. Assert rst_n=0 at cycle 15 of a DIV -> busy, hi and lo go to 0 immediately; no done pulse.
//      MTLO 0x1234 then issued in IDLE -> lo=0x1234 on the next edge.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add MULT/MULTU, restoring DIV/DIVU, one bit per cycle.
// Latency WIDTH cycles from start to done; start and MTHI/MTLO are ignored while busy.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rs_hold;
  logic               res_neg;
  logic               dvd_neg;
  logic               dz;

  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_res;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff, div_rem, quo, quo_fix, rem_fix;
  logic               last;

  always_comb begin
    rs_neg    = ~op[0] & rs_data[WIDTH-1];
    rt_neg    = ~op[0] & rt_data[WIDTH-1];
    rs_mag    = rs_neg ? -rs_data : rs_data;
    rt_mag    = rt_neg ? -rt_data : rt_data;
    // Multiply: prod holds {partial sum, remaining multiplier bits}, shifted right each step.
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, prod[WIDTH-1:1]};
    mul_res   = res_neg ? -mul_next : mul_next;
    // Divide: prod holds {remainder, dividend/quotient}, shifted left each step.
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    quo       = {prod[WIDTH-2:0], div_ge};
    quo_fix   = res_neg ? -quo : quo;
    rem_fix   = dvd_neg ? -div_rem : div_rem;
    last      = (cnt == CNT_W'(WIDTH-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      opnd        <= '0;
      prod        <= '0;
      rs_hold     <= '0;
      res_neg     <= 1'b0;
      dvd_neg     <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            res_neg     <= rs_neg ^ rt_neg;
            dvd_neg     <= rs_neg;
            rs_hold     <= rs_data;
            dz          <= op[1] & (rt_data == '0);
            if (op[1]) begin
              opnd  <= rt_mag;
              prod  <= {{WIDTH{1'b0}}, rs_mag};
              state <= DIV;
            end else begin
              opnd  <= rs_mag;
              prod  <= {{WIDTH{1'b0}}, rt_mag};
              state <= MUL;
            end
          end
        end
        MUL: begin
          prod <= mul_next;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            hi    <= mul_res[2*WIDTH-1:WIDTH];
            lo    <= mul_res[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        DIV: begin
          prod <= {div_rem, quo};
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            // A zero divisor returns all-ones quotient and the original dividend.
            hi          <= dz ? rs_hold : rem_fix;
            lo          <= dz ? {WIDTH{1'b1}} : quo_fix;
            div_by_zero <= dz;
            done        <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
